// File: rtl/adder_checker.sv
// Scoreboard for a pipelined adder: delays golden sums by LATENCY and compares against the DUT result.
// Optional first-mismatch capture is enabled with the ADDER_CHK_CAPTURE_EN macro.
module adder_checker #(
  parameter int unsigned NB_BITS = 16,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned MAX_ERR = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [NB_BITS-1:0] i_sampleA,
  input  logic [NB_BITS-1:0] i_sampleB,
  input  logic               i_carry,
  input  logic [NB_BITS:0]   i_sum,
  output logic               o_error,
  output logic [15:0]        o_err_count,
  output logic [15:0]        o_chk_count,
  output logic [1:0]         o_state,
  output logic [NB_BITS:0]   o_first_exp,
  output logic [NB_BITS:0]   o_first_got
);

  localparam int unsigned SUM_W     = NB_BITS + 1;
  localparam int unsigned CNT_W     = 16;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   ERR_LIMIT = (CNT_W+1)'(MAX_ERR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [SUM_W-1:0]   golden_c;
  logic [LATENCY-1:0] sr_valid;
  logic [SUM_W-1:0]   sr_gold [LATENCY];
  logic               tail_valid_c;
  logic [SUM_W-1:0]   tail_gold_c;
  logic               cmp_en_c;
  logic               mismatch_c;
  logic               err_hit_c;

  // Reference sum keeps the carry-out in the MSB
  always_comb begin
    golden_c = SUM_W'(i_sampleA) + SUM_W'(i_sampleB) + SUM_W'(i_carry);
  end

  // Delay line: one entry pushed every cycle, bubbles included
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_valid <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        sr_gold[i] <= '0;
      end
    end else begin
      sr_valid[0] <= i_valid;
      sr_gold[0]  <= golden_c;
      for (int i = 1; i < int'(LATENCY); i++) begin
        sr_valid[i] <= sr_valid[i-1];
        sr_gold[i]  <= sr_gold[i-1];
      end
    end
  end

  always_comb begin
    tail_valid_c = sr_valid[LATENCY-1];
    tail_gold_c  = sr_gold[LATENCY-1];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM output decode: comparisons only while filling or checking
  always_comb begin
    cmp_en_c   = 1'b0;
    mismatch_c = 1'b0;
    err_hit_c  = 1'b0;
    if ((state == FILL) || (state == CHECK)) begin
      cmp_en_c = tail_valid_c;
    end
    mismatch_c = cmp_en_c && (tail_gold_c != i_sum);
    err_hit_c  = mismatch_c && (((CNT_W+1)'(o_err_count) + (CNT_W+1)'(1)) >= ERR_LIMIT);
  end

  // FSM next-state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (i_valid) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (err_hit_c) begin
          state_nxt = HALT;
        end else if (cmp_en_c) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (err_hit_c) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign o_state = state;

  // Saturating comparison / mismatch counters and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      o_chk_count <= '0;
      o_err_count <= '0;
      o_error     <= 1'b0;
    end else begin
      if (cmp_en_c && (o_chk_count != CNT_MAX)) begin
        o_chk_count <= o_chk_count + CNT_W'(1);
      end
      if (mismatch_c) begin
        o_error <= 1'b1;
        if (o_err_count != CNT_MAX) begin
          o_err_count <= o_err_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef ADDER_CHK_CAPTURE_EN
  // First mismatch after reset is latched and never overwritten
  always_ff @(posedge clk) begin
    if (rst) begin
      o_first_exp <= '0;
      o_first_got <= '0;
    end else if (mismatch_c && !o_error) begin
      o_first_exp <= tail_gold_c;
      o_first_got <= i_sum;
    end
  end
`else
  assign o_first_exp = '0;
  assign o_first_got = '0;
`endif

endmodule

// File: tb/tb_adder_checker.sv
// Randomized self-checking bench: two checker instances (LATENCY=1/MAX_ERR=2 and LATENCY=3/MAX_ERR=16)
// compared every cycle against a history-based model, plus literal expectations for the key scenarios.
module tb_adder_checker;

  localparam int L0 = 1;
  localparam int L1 = 3;
  localparam int ME0 = 2;
  localparam int ME1 = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        carry;
  logic [16:0] isum   [2];
  logic        err_o  [2];
  logic [15:0] errc   [2];
  logic [15:0] chkc   [2];
  logic [1:0]  st_o   [2];
  logic [16:0] fexp   [2];
  logic [16:0] fgot   [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder_checker #(.NB_BITS(16), .LATENCY(L0), .MAX_ERR(ME0)) u0 (
    .clk(clk), .rst(rst), .i_valid(valid), .i_sampleA(a), .i_sampleB(b), .i_carry(carry),
    .i_sum(isum[0]), .o_error(err_o[0]), .o_err_count(errc[0]), .o_chk_count(chkc[0]),
    .o_state(st_o[0]), .o_first_exp(fexp[0]), .o_first_got(fgot[0])
  );

  adder_checker #(.NB_BITS(16), .LATENCY(L1), .MAX_ERR(ME1)) u1 (
    .clk(clk), .rst(rst), .i_valid(valid), .i_sampleA(a), .i_sampleB(b), .i_carry(carry),
    .i_sum(isum[1]), .o_error(err_o[1]), .o_err_count(errc[1]), .o_chk_count(chkc[1]),
    .o_state(st_o[1]), .o_first_exp(fexp[1]), .o_first_got(fgot[1])
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Model: per-edge history of {valid, sum}; an entry is due LATENCY edges after it was sampled
  bit mv  [2][16];
  int mg  [2][16];
  int mn  [2];
  int mst [2];
  int merr[2];
  int mchk[2];
  bit merror[2];
  int mfe [2];
  int mfg [2];
  bit model_on = 1'b0;

  function automatic void model_step(input int k);
    int  lat;
    int  me;
    int  g;
    int  idx;
    int  nst;
    bit  cmp;
    bit  mis;
    lat = (k == 0) ? L0 : L1;
    me  = (k == 0) ? ME0 : ME1;
    g   = int'(a) + int'(b) + int'(carry);
    if (rst) begin
      mn[k] = 0; mst[k] = 0; merr[k] = 0; mchk[k] = 0; merror[k] = 1'b0;
      mfe[k] = 0; mfg[k] = 0;
      model_on = 1'b1;
    end else begin
      cmp = 1'b0;
      mis = 1'b0;
      if (mn[k] >= lat) begin
        idx = (mn[k] - lat) % 16;
        cmp = mv[k][idx] && (mst[k] == 1 || mst[k] == 2);
        if (cmp) mis = (mg[k][idx] != int'(isum[k]));
      end
      nst = mst[k];
      if (mst[k] == 0 && valid) nst = 1;
      else if (cmp && mis && (merr[k] + 1 >= me)) nst = 3;
      else if (mst[k] == 1 && cmp) nst = 2;
      if (cmp && mchk[k] < 65535) mchk[k]++;
      if (mis) begin
`ifdef ADDER_CHK_CAPTURE_EN
        if (!merror[k]) begin
          mfe[k] = mg[k][(mn[k] - lat) % 16];
          mfg[k] = int'(isum[k]);
        end
`endif
        merror[k] = 1'b1;
        if (merr[k] < 65535) merr[k]++;
      end
      mst[k] = nst;
      mv[k][mn[k] % 16] = valid;
      mg[k][mn[k] % 16] = g;
      mn[k]++;
    end
  endfunction

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  // Compare every DUT output against the model on the falling edge
  always @(negedge clk) begin
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("u%0d.o_state", k),     32'(st_o[k]),   32'(mst[k]));
        chk($sformatf("u%0d.o_chk_count", k), 32'(chkc[k]),   32'(mchk[k]));
        chk($sformatf("u%0d.o_err_count", k), 32'(errc[k]),   32'(merr[k]));
        chk($sformatf("u%0d.o_error", k),     32'(err_o[k]),  32'(merror[k]));
        chk($sformatf("u%0d.o_first_exp", k), 32'(fexp[k]),   32'(mfe[k]));
        chk($sformatf("u%0d.o_first_got", k), 32'(fgot[k]),   32'(mfg[k]));
      end
    end
  end

  // Stimulus: planned DUT results are replayed on i_sum LATENCY cycles after their operands
  int plan[2][16];
  int cyc = 0;

  task automatic drive(input bit v, input bit [15:0] aa, input bit [15:0] bb, input bit c,
                       input bit bad0, input bit bad1, input bit r);
    int g;
    @(negedge clk);
    rst = r; valid = v; a = aa; b = bb; carry = c;
    g = int'(aa) + int'(bb) + int'(c);
    plan[0][cyc % 16] = v ? (bad0 ? (g ^ 1) : g) : int'($urandom & 32'h1FFFF);
    plan[1][cyc % 16] = v ? (bad1 ? (g ^ 1) : g) : int'($urandom & 32'h1FFFF);
    isum[0] = (cyc >= L0) ? 17'(plan[0][(cyc - L0) % 16]) : 17'h0;
    isum[1] = (cyc >= L1) ? 17'(plan[1][(cyc - L1) % 16]) : 17'h0;
    cyc++;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0, r);
  endtask

  task automatic rnd_valid(input bit bad0, input bit bad1);
    drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), bad0, bad1, 1'b0);
  endtask

  initial begin
    int cnt;
    bit v;
    rst = 1'b1; valid = 1'b0; a = '0; b = '0; carry = 1'b0;
    isum[0] = '0; isum[1] = '0;
    idle(3, 1'b1);
    idle(1, 1'b0);
    chk("reset state", 32'(st_o[1]), 32'd0);
    chk("reset chk",   32'(chkc[0]), 32'd0);

    // FFFF + 0001 + 1 = 10001, correct result
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5, 1'b0);
    chk("carry-out chk_count", 32'(chkc[0]), 32'd1);
    chk("carry-out err_count", 32'(errc[0]), 32'd0);
    chk("carry-out error",     32'(err_o[0]), 32'd0);
    chk("carry-out chk_count L3", 32'(chkc[1]), 32'd1);

    // 1234 + 1111 = 02345, DUT reports 02344
    drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b0);
    chk("mismatch error",     32'(err_o[0]), 32'd1);
    chk("mismatch err_count", 32'(errc[0]), 32'd1);
`ifdef ADDER_CHK_CAPTURE_EN
    chk("capture exp", 32'(fexp[0]), 32'h02345);
    chk("capture got", 32'(fgot[0]), 32'h02344);
`else
    chk("no-capture exp", 32'(fexp[0]), 32'h0);
    chk("no-capture got", 32'(fgot[0]), 32'h0);
`endif

    // Three forced mismatches: MAX_ERR=2 instance halts after the second
    idle(2, 1'b1);
    for (int i = 0; i < 3; i++) rnd_valid(1'b1, 1'b1);
    idle(6, 1'b0);
    chk("halt state",     32'(st_o[0]), 32'd3);
    chk("halt err_count", 32'(errc[0]), 32'd2);
    chk("halt chk_count", 32'(chkc[0]), 32'd2);
    chk("no-halt err_count", 32'(errc[1]), 32'd3);

    // LATENCY=3: 10 valids then 3 bubbles
    idle(2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      rnd_valid(1'b0, 1'b0);
      if (i == 1 || i == 3) chk($sformatf("fill state @%0d", i), 32'(st_o[1]), 32'd1);
      if (i == 4)           chk("check state", 32'(st_o[1]), 32'd2);
    end
    idle(3, 1'b0);
    idle(2, 1'b0);
    chk("burst chk_count", 32'(chkc[1]), 32'd10);
    chk("burst state",     32'(st_o[1]), 32'd2);

    // Reset with two entries in flight, wrong results replayed afterwards
    idle(2, 1'b1);
    rnd_valid(1'b1, 1'b1);
    rnd_valid(1'b1, 1'b1);
    idle(1, 1'b1);
    idle(6, 1'b0);
    chk("flush err_count", 32'(errc[1]), 32'd0);
    chk("flush chk_count", 32'(chkc[1]), 32'd0);
    chk("flush state",     32'(st_o[1]), 32'd0);

    // 1000 random valids with random bubbles, ideal adder
    idle(2, 1'b1);
    cnt = 0;
    while (cnt < 1000) begin
      v = ($urandom_range(0, 3) != 0);
      if (v) rnd_valid(1'b0, 1'b0);
      else idle(1, 1'b0);
      cnt += int'(v);
    end
    idle(5, 1'b0);
    chk("random chk_count L1", 32'(chkc[0]), 32'd1000);
    chk("random chk_count L3", 32'(chkc[1]), 32'd1000);
    chk("random error L1",     32'(err_o[0]), 32'd0);
    chk("random error L3",     32'(err_o[1]), 32'd0);

    for (int i = 0; i < 3; i++) rnd_valid(1'b0, 1'b1);
    idle(5, 1'b0);
    chk("late err_count", 32'(errc[1]), 32'd3);
`ifndef ADDER_CHK_CAPTURE_EN
    chk("late first_exp", 32'(fexp[1]), 32'h0);
    chk("late first_got", 32'(fgot[1]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
